// File: rtl/if_id_register.sv
// IF/ID pipeline register: ID copy of the fetched instruction, the
// feedback fields Fetch's hazard logic consumes, IAR and perf counters.
module if_id_register #(
  parameter logic [5:0]  NopOp      = 6'h00,
  parameter logic [5:0]  NopFunct   = 6'h15,
  parameter logic [5:0]  TrapOp     = 6'h11,
  parameter int unsigned CountWidth = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [0:5]            OpCode,
  input  logic [0:5]            Function,
  input  logic [0:31]           PCPlusFour,
  input  logic [0:4]            Rs1,
  input  logic [0:4]            Rs2,
  input  logic [0:4]            Rd,
  input  logic [0:15]           Immediate,
  output logic [0:5]            IdOpCode,
  output logic [0:5]            IdFunction,
  output logic [0:4]            IdRs1,
  output logic [0:4]            IdRs2,
  output logic [0:4]            IdRd,
  output logic [0:15]           IdImmediate,
  output logic [0:31]           DecodePCPlusFour,
  output logic [0:5]            DecodeOpCode,
  output logic [0:5]            DecodeRd,
  output logic                  IdValid,
  output logic [0:31]           IAR,
  output logic [CountWidth-1:0] InstrCount,
  output logic [CountWidth-1:0] BubbleCount
);

  logic       in_bubble;
  logic       load_bubble;
  logic       trap_capture;
  logic [0:5] rd_next;

  assign in_bubble    = (OpCode == NopOp) && (Function == NopFunct);
  assign load_bubble  = flush || in_bubble;
  assign trap_capture = IdValid && (IdOpCode == TrapOp);
  assign DecodeOpCode = IdOpCode;

  // Destination as {fp, reg}; zero means "no register written".
  always_comb begin
    rd_next = '0;
    if (!load_bubble) begin
      unique case (OpCode) inside
        6'h00: rd_next = {1'b0, Rd};
        6'h01: rd_next = {1'b1, Rd};
        [6'h20:6'h25],
        [6'h08:6'h0f],
        [6'h18:6'h1d]: rd_next = {1'b0, Rs2};
        6'h26, 6'h27:  rd_next = {1'b1, Rs2};
        6'h03, 6'h13:  rd_next = {1'b0, 5'd31};
        default:       rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      IdOpCode         <= NopOp;
      IdFunction       <= NopFunct;
      IdRs1            <= '0;
      IdRs2            <= '0;
      IdRd             <= '0;
      IdImmediate      <= '0;
      DecodePCPlusFour <= '0;
      DecodeRd         <= '0;
      IdValid          <= 1'b0;
      IAR              <= '0;
      InstrCount       <= '0;
      BubbleCount      <= '0;
    end else if (!stall) begin
      if (flush) begin
        IdOpCode    <= NopOp;
        IdFunction  <= NopFunct;
        IdRs1       <= '0;
        IdRs2       <= '0;
        IdRd        <= '0;
        IdImmediate <= '0;
      end else begin
        IdOpCode    <= OpCode;
        IdFunction  <= Function;
        IdRs1       <= Rs1;
        IdRs2       <= Rs2;
        IdRd        <= Rd;
        IdImmediate <= Immediate;
      end
      DecodePCPlusFour <= PCPlusFour;
      DecodeRd         <= rd_next;
      IdValid          <= !load_bubble;
      // Stalled edges never reach here, so a trap is captured once.
      if (trap_capture) begin
        IAR <= DecodePCPlusFour;
      end
      if (load_bubble) begin
        if (BubbleCount != '1) begin
          BubbleCount <= BubbleCount + 1'b1;
        end
      end else begin
        if (InstrCount != '1) begin
          InstrCount <= InstrCount + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_id_register.sv
// Directed bench for if_id_register: reset, flow, stall, flush,
// TRAP capture into IAR, FP decode and counter saturation.
module tb_if_id_register;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [0:5]  OpCode, Function;
  logic [0:31] PCPlusFour;
  logic [0:4]  Rs1, Rs2, Rd;
  logic [0:15] Immediate;

  logic [0:5]  IdOpCode, IdFunction, DecodeOpCode, DecodeRd;
  logic [0:4]  IdRs1, IdRs2, IdRd;
  logic [0:15] IdImmediate;
  logic [0:31] DecodePCPlusFour, IAR;
  logic        IdValid;
  logic [31:0] InstrCount, BubbleCount;

  logic [0:5]  s_op, s_fn, s_dop, s_drd;
  logic [0:4]  s_rs1, s_rs2, s_rd;
  logic [0:15] s_imm;
  logic [0:31] s_pc, s_iar;
  logic        s_valid;
  logic [3:0]  s_ic, s_bc;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  if_id_register dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .OpCode(OpCode), .Function(Function), .PCPlusFour(PCPlusFour),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Immediate(Immediate),
    .IdOpCode(IdOpCode), .IdFunction(IdFunction),
    .IdRs1(IdRs1), .IdRs2(IdRs2), .IdRd(IdRd),
    .IdImmediate(IdImmediate), .DecodePCPlusFour(DecodePCPlusFour),
    .DecodeOpCode(DecodeOpCode), .DecodeRd(DecodeRd),
    .IdValid(IdValid), .IAR(IAR),
    .InstrCount(InstrCount), .BubbleCount(BubbleCount)
  );

  if_id_register #(.CountWidth(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .OpCode(OpCode), .Function(Function), .PCPlusFour(PCPlusFour),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Immediate(Immediate),
    .IdOpCode(s_op), .IdFunction(s_fn),
    .IdRs1(s_rs1), .IdRs2(s_rs2), .IdRd(s_rd),
    .IdImmediate(s_imm), .DecodePCPlusFour(s_pc),
    .DecodeOpCode(s_dop), .DecodeRd(s_drd),
    .IdValid(s_valid), .IAR(s_iar),
    .InstrCount(s_ic), .BubbleCount(s_bc)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] op, input logic [5:0] fn,
                     input logic [31:0] pc, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd,
                     input logic [15:0] imm);
    OpCode = op; Function = fn; PCPlusFour = pc;
    Rs1 = r1; Rs2 = r2; Rd = rd; Immediate = imm;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stall = 1'($urandom); flush = 1'($urandom);
      put(6'($urandom), 6'($urandom), $urandom, 5'($urandom),
          5'($urandom), 5'($urandom), 16'($urandom));
      tick();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    chk("rst_op", IdOpCode, 6'h00);
    chk("rst_fn", IdFunction, 6'h15);
    chk("rst_valid", IdValid, 1'b0);
    chk("rst_drd", DecodeRd, 6'h00);
    chk("rst_pc", DecodePCPlusFour, 32'h0);
    chk("rst_iar", IAR, 32'h0);
    chk("rst_ic", InstrCount, 32'd0);
    chk("rst_bc", BubbleCount, 32'd0);
    chk("rst_ic4", s_ic, 4'd0);

    put(6'h00, 6'h20, 32'h100, 5'd1, 5'd2, 5'd5, 16'h0);
    tick();
    chk("add_drd", DecodeRd, 6'h05);
    chk("add_fn", IdFunction, 6'h20);
    chk("add_valid", IdValid, 1'b1);
    chk("add_pc", DecodePCPlusFour, 32'h100);
    put(6'h23, 6'h00, 32'h104, 5'd3, 5'd7, 5'd0, 16'h0010);
    tick();
    chk("lw_drd", DecodeRd, 6'h07);
    chk("lw_imm", IdImmediate, 16'h0010);
    chk("lw_rs1", IdRs1, 5'd3);
    put(6'h03, 6'h00, 32'h108, 5'd0, 5'd0, 5'd0, 16'h0040);
    tick();
    chk("jal_drd", DecodeRd, 6'h1f);
    chk("jal_dop", DecodeOpCode, 6'h03);
    chk("flow_ic", InstrCount, 32'd3);
    chk("flow_bc", BubbleCount, 32'd0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(6'h08 + 6'(i), 6'h00, 32'h200 + 32'(i), 5'd4, 5'd9, 5'd1,
          16'(i));
      tick();
      chk("stall_op", IdOpCode, 6'h03);
      chk("stall_pc", DecodePCPlusFour, 32'h108);
      chk("stall_ic", InstrCount, 32'd3);
    end
    stall = 1'b0;
    put(6'h08, 6'h00, 32'h10c, 5'd4, 5'd9, 5'd1, 16'h0);
    tick();
    chk("rel_op", IdOpCode, 6'h08);
    chk("rel_drd", DecodeRd, 6'h09);
    chk("rel_ic", InstrCount, 32'd4);

    flush = 1'b1;
    put(6'h2b, 6'h00, 32'h110, 5'd2, 5'd6, 5'd0, 16'h0008);
    tick();
    chk("fl_op", IdOpCode, 6'h00);
    chk("fl_fn", IdFunction, 6'h15);
    chk("fl_valid", IdValid, 1'b0);
    chk("fl_drd", DecodeRd, 6'h00);
    chk("fl_pc", DecodePCPlusFour, 32'h110);
    chk("fl_bc", BubbleCount, 32'd1);
    stall = 1'b1;
    put(6'h2b, 6'h00, 32'h114, 5'd2, 5'd6, 5'd0, 16'h0008);
    tick();
    chk("flst_pc", DecodePCPlusFour, 32'h110);
    chk("flst_bc", BubbleCount, 32'd1);
    chk("flst_ic", InstrCount, 32'd4);
    stall = 1'b0; flush = 1'b0;
    put(6'h00, 6'h15, 32'h114, 5'd0, 5'd0, 5'd3, 16'h0);
    tick();
    chk("nop_valid", IdValid, 1'b0);
    chk("nop_drd", DecodeRd, 6'h00);
    chk("nop_bc", BubbleCount, 32'd2);

    put(6'h11, 6'h00, 32'h104, 5'd0, 5'd0, 5'd0, 16'h0);
    tick();
    chk("trap_op", IdOpCode, 6'h11);
    chk("trap_drd", DecodeRd, 6'h00);
    chk("trap_iar0", IAR, 32'h0);
    put(6'h08, 6'h00, 32'h108, 5'd0, 5'd1, 5'd0, 16'h0);
    tick();
    chk("trap_iar", IAR, 32'h104);
    put(6'h11, 6'h00, 32'h204, 5'd0, 5'd0, 5'd0, 16'h0);
    tick();
    stall = 1'b1;
    tick();
    chk("trst_iar1", IAR, 32'h104);
    tick();
    chk("trst_iar2", IAR, 32'h104);
    stall = 1'b0;
    put(6'h08, 6'h00, 32'h208, 5'd0, 5'd1, 5'd0, 16'h0);
    tick();
    chk("trst_iar3", IAR, 32'h204);
    chk("trst_ic", InstrCount, 32'd8);

    put(6'h26, 6'h00, 32'h20c, 5'd1, 5'd3, 5'd0, 16'h0);
    tick();
    chk("lf_drd", DecodeRd, 6'h23);
    put(6'h01, 6'h02, 32'h210, 5'd1, 5'd2, 5'd4, 16'h0);
    tick();
    chk("fpr_drd", DecodeRd, 6'h24);
    put(6'h2b, 6'h00, 32'h214, 5'd1, 5'd2, 5'd4, 16'h0);
    tick();
    chk("sw_drd", DecodeRd, 6'h00);
    chk("sw_valid", IdValid, 1'b1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      put(6'h08, 6'h00, 32'h300 + 32'(4 * i), 5'd0, 5'(i), 5'd0, 16'h0);
      tick();
    end
    chk("sat_ic4", s_ic, 4'hf);
    chk("sat_bc4", s_bc, 4'h0);
    chk("sat_ic32", InstrCount, 32'd20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_fl_ic4", s_ic, 4'hf);
    chk("sat_fl_bc4", s_bc, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
